// File: rtl/minmax_if.sv
// Controller-side bundle for the min/max tracker: run control, sample handshake,
// datapath flags/strobes and status.
interface minmax_if #(parameter int CNT_W = 16);
  logic             start;
  logic [CNT_W-1:0] n_samples;
  logic             in_valid;
  logic             in_ready;
  logic             A_lt_B;
  logic             C_gt_D;
  logic             reg_clr;
  logic             reg_ld;
  logic             min_clr;
  logic             min_ld;
  logic             max_clr;
  logic             max_ld;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] sample_cnt;

  modport master (
    input  start, n_samples, in_valid, A_lt_B, C_gt_D,
    output in_ready, reg_clr, reg_ld, min_clr, min_ld, max_clr, max_ld,
           busy, done, sample_cnt
  );

  modport slave (
    output start, n_samples, in_valid, A_lt_B, C_gt_D,
    input  in_ready, reg_clr, reg_ld, min_clr, min_ld, max_clr, max_ld,
           busy, done, sample_cnt
  );
endinterface

// File: rtl/minmax_controller.sv
// Sequencer for the min/max datapath: clears it, pulls n samples over valid/ready,
// and steers min/max loads from the registered compare flags.
module minmax_controller #(
  parameter int CNT_W = 16
) (
  input  logic     clk,
  input  logic     rst,
  minmax_if.master bus
);

  typedef enum logic [2:0] {IDLE, CLEAR, WAIT, EVAL, UPDATE, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] n_lat;
  logic [CNT_W-1:0] cnt;
  logic             in_ready_q;
  logic             clr_q;
  logic             busy_q;
  logic             done_q;
  logic             last;

  assign last = (cnt + CNT_W'(1)) == n_lat;

  // State-decoded outputs are registered alongside the next state so they
  // line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      n_lat      <= '0;
      cnt        <= '0;
      in_ready_q <= 1'b0;
      clr_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      in_ready_q <= 1'b0;
      clr_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b1;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            n_lat <= bus.n_samples;
            cnt   <= '0;
            clr_q <= 1'b1;
            state <= CLEAR;
          end else begin
            busy_q <= 1'b0;
          end
        end
        CLEAR: begin
          if (n_lat == '0) begin
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            in_ready_q <= 1'b1;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (bus.in_valid) state <= EVAL;
          else              in_ready_q <= 1'b1;
        end
        EVAL: state <= UPDATE;
        UPDATE: begin
          cnt <= cnt + CNT_W'(1);
          if (last) begin
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            in_ready_q <= 1'b1;
            state      <= WAIT;
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // Flags are already registered in the datapath, so gating them by state is safe.
  assign bus.reg_ld     = (state == WAIT) && bus.in_valid;
  assign bus.min_ld     = (state == UPDATE) && bus.A_lt_B;
  assign bus.max_ld     = (state == UPDATE) && bus.C_gt_D;
  assign bus.in_ready   = in_ready_q;
  assign bus.reg_clr    = clr_q;
  assign bus.min_clr    = clr_q;
  assign bus.max_clr    = clr_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.sample_cnt = cnt;

endmodule

// File: tb/tb_minmax_controller.sv
// Bench for minmax_controller: behavioural datapath, valid/ready sample source,
// expected-result scoreboard popped by a done monitor.
module tb_minmax_controller;
  localparam int CNT_W = 16;
  localparam logic signed [31:0] MIN_CLR = 32'sh7FFFFFFF;
  localparam logic signed [31:0] MAX_CLR = 32'sh80000000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  minmax_if #(.CNT_W(CNT_W)) bus();
  minmax_controller #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic logic [8:0] outs();
    return {bus.busy, bus.done, bus.in_ready, bus.reg_clr, bus.reg_ld,
            bus.min_clr, bus.min_ld, bus.max_clr, bus.max_ld};
  endfunction

  // Datapath model: sample register, running min/max, registered compare flags
  logic signed [31:0] din, dp_r, dp_min, dp_max;
  always @(posedge clk) begin
    if (rst) begin
      dp_r <= 0; dp_min <= 0; dp_max <= 0;
      bus.A_lt_B <= 1'b0; bus.C_gt_D <= 1'b0;
    end else begin
      if (bus.reg_clr) dp_r <= 0; else if (bus.reg_ld) dp_r <= din;
      if (bus.min_clr) dp_min <= MIN_CLR; else if (bus.min_ld) dp_min <= dp_r;
      if (bus.max_clr) dp_max <= MAX_CLR; else if (bus.max_ld) dp_max <= dp_r;
      bus.A_lt_B <= dp_r < dp_min;
      bus.C_gt_D <= dp_r > dp_max;
    end
  end

  // Sample source: each item waits `gap` in_ready cycles with in_valid low
  typedef struct { int gap; logic signed [31:0] val; } item_t;
  item_t src_q[$];
  initial begin
    item_t cur;
    bit    have;
    bit    xfer;
    bit    rs;
    have = 0;
    bus.in_valid = 1'b0;
    din = 0;
    forever begin
      @(negedge clk);
      xfer = bus.in_valid && bus.in_ready;
      rs   = rst;
      @(posedge clk); #1;
      if (rs) begin
        have = 0; src_q.delete(); bus.in_valid = 1'b0;
      end else begin
        if (xfer) begin have = 0; bus.in_valid = 1'b0; end
        if (!have && src_q.size() > 0) begin cur = src_q.pop_front(); have = 1; end
        if (have) begin
          if (cur.gap == 0) begin bus.in_valid = 1'b1; din = cur.val; end
          else if (bus.in_ready) cur.gap--;
        end
      end
    end
  end

  // Scoreboard
  typedef struct { int n; int done_cyc; int rdy; logic signed [31:0] mn, mx; } exp_t;
  exp_t exp_q[$];
  int ld_cnt = 0;
  int rdy_cnt = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        ld_cnt = 0; rdy_cnt = 0;
      end else begin
        if (bus.reg_ld) begin
          ld_cnt++;
          chk("reg_ld_outside_wait", bus.in_ready, 1);
        end
        if (bus.in_ready) rdy_cnt++;
        if (bus.done) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL spurious_done: got done=1 want no done (cycle %0d)", cyc);
          end else begin
            e = exp_q.pop_front();
            chk("done_cycle", cyc, e.done_cyc);
            chk("sample_cnt", bus.sample_cnt, e.n);
            chk("min", dp_min, e.mn);
            chk("max", dp_max, e.mx);
            chk("reg_ld_count", ld_cnt, e.n);
            chk("in_ready_cycles", rdy_cnt, e.rdy);
          end
          ld_cnt = 0; rdy_cnt = 0;
        end
      end
    end
  end

  // Stimulus
  logic signed [31:0] fix_q[$];
  int t0;

  task automatic goto(input int c);
    while (cyc < c) begin @(posedge clk); #1; end
  endtask

  // pre = cycles start is held before the accepting cycle (those cycles must be ignored)
  task automatic issue(input int n, input int gap, input int pre);
    exp_t e;
    item_t it;
    logic signed [31:0] v;
    e.n = n; e.mn = MIN_CLR; e.mx = MAX_CLR; e.rdy = n * (gap + 1);
    for (int i = 0; i < n; i++) begin
      v = (fix_q.size() > 0) ? fix_q.pop_front() : $urandom;
      if (v < e.mn) e.mn = v;
      if (v > e.mx) e.mx = v;
      it.gap = gap; it.val = v;
      src_q.push_back(it);
    end
    t0 = cyc + pre;
    e.done_cyc = t0 + 3 * n + 2 + n * gap;
    exp_q.push_back(e);
    bus.start = 1'b1;
    bus.n_samples = CNT_W'(n);
    repeat (pre + 1) begin @(posedge clk); #1; end
    bus.start = 1'b0;
    bus.n_samples = CNT_W'($urandom);
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (bus.busy && k < 2000) begin @(posedge clk); #1; k++; end
    if (bus.busy) begin
      total++; bad++;
      $display("FAIL %s_timeout: got busy=1 want busy=0", nm);
    end
  endtask

  initial begin
    int base;
    bus.start = 1'b0;
    bus.n_samples = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", outs(), 0);
    chk("reset_cnt", bus.sample_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // basic run, held-high valid
    fix_q = '{32'sd5, -32'sd3, 32'sd12, 32'sd0};
    issue(4, 0, 0);
    wait_idle("t1");
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("cnt_hold_idle", bus.sample_cnt, 4);
    chk("idle_outs", outs(), 0);
    @(posedge clk); #1;

    // empty run
    issue(0, 0, 0);
    @(negedge clk);
    chk("clear_pulse", {bus.reg_clr, bus.min_clr, bus.max_clr, bus.busy}, 4'b1111);
    wait_idle("t2");

    // gapped source
    issue(3, 5, 0);
    wait_idle("t3");

    // single sample loads both min and max
    fix_q = '{32'sd7};
    issue(1, 0, 0);
    goto(t0 + 4);
    @(negedge clk);
    chk("both_ld", {bus.min_ld, bus.max_ld}, 2'b11);
    wait_idle("t4");

    // extreme first samples
    fix_q = '{MIN_CLR};
    issue(3, 0, 0);
    wait_idle("ext_hi");
    fix_q = '{MAX_CLR};
    issue(3, 1, 0);
    wait_idle("ext_lo");

    // abort mid-run
    issue(5, 0, 0);
    goto(t0 + 6);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("abort_outs", outs(), 0);
    chk("abort_cnt", bus.sample_cnt, 0);
    repeat (2) begin @(posedge clk); #1; end
    issue(2, 0, 0);
    wait_idle("t5");

    // stray starts mid-run, then start held across DONE into IDLE
    issue(4, 0, 0);
    base = t0;
    goto(base + 3);
    bus.start = 1'b1; bus.n_samples = CNT_W'(9);
    @(posedge clk); #1;
    bus.start = 1'b0;
    goto(base + 8);
    bus.start = 1'b1; bus.n_samples = CNT_W'(9);
    @(posedge clk); #1;
    bus.start = 1'b0;
    goto(base + 14);
    issue(2, 0, 1);
    wait_idle("t6");

    // random runs
    for (int r = 0; r < 8; r++) begin
      if ($urandom_range(0, 2) == 0) fix_q = '{($urandom_range(0, 1) == 1) ? MIN_CLR : MAX_CLR};
      issue(int'($urandom_range(0, 6)), int'($urandom_range(0, 3)), 0);
      wait_idle("rand");
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
